// File: rtl/mux_sel_arbiter_if.sv
// Bundle between the four requesting units, the shared resource and the arbiter.
// Handshake: a requester holds req[i] high for as long as it wants the resource. It owns the
// resource in every cycle where grant[i]=1. done is a one-cycle pulse from the resource that
// ends the current ownership. done is ignored while nothing is granted.
interface mux_sel_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout_err;

    modport master (output req, done, input grant, sel, busy, timeout_err);
    modport slave  (input req, done, output grant, sel, busy, timeout_err);
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for four requesters sharing one mux_4x1 path. A watchdog releases a
// grant that is held too long, and the next owner is granted on the same edge as the release.
module mux_sel_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    mux_sel_arbiter_if.slave  bus,
    output logic [0:0]        state_dbg
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               terr_q, terr_d;
    logic [2:0]         pick;
    logic               at_limit;
    logic               release_now;

    // The search runs from last+1 around to last itself. A sole requester that was just
    // served can therefore win again.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, last};
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign pick        = rr_pick(bus.req, last_q);
    assign at_limit    = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign release_now = bus.done || !bus.req[sel_q] || at_limit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    grant_d = 4'b0001 << pick[1:0];
                    sel_d   = pick[1:0];
                    last_d  = pick[1:0];
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    terr_d = at_limit && !bus.done;
                    cnt_d  = '0;
                    if (pick[2]) begin
                        grant_d = 4'b0001 << pick[1:0];
                        sel_d   = pick[1:0];
                        last_d  = pick[1:0];
                    end else begin
                        grant_d = 4'b0000;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.sel         = sel_q;
    assign bus.busy        = |grant_q;
    assign bus.timeout_err = terr_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter. It applies a table of directed vectors, then hand-written
// timeout, reset and abort sequences, then random traffic checked against a round-robin model.
module tb_mux_sel_arbiter;
    localparam int TIMEOUT = 16;

    logic       clk;
    logic       reset_n;
    logic [0:0] state_dbg;
    int         n_checks;
    int         n_errors;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: owner is the index currently served (-1 when none), age counts the cycles the
    // current grant has been visible, last_won is the most recent winner.
    int         m_owner;
    int         m_age;
    int         m_last;
    logic [1:0] m_sel;
    logic       m_terr;

    function automatic void model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 3;
        m_sel   = 2'd0;
        m_terr  = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic d);
        bit free;
        int cand;
        m_terr = 1'b0;
        if (m_owner >= 0) begin
            free   = d || !r[m_owner] || (m_age == TIMEOUT);
            m_terr = (m_age == TIMEOUT) && !d;
            if (!free) begin
                m_age = m_age + 1;
                return;
            end
        end
        m_owner = -1;
        for (int k = 1; k <= 4; k++) begin
            cand = (m_last + k) % 4;
            if (m_owner < 0 && r[cand]) m_owner = cand;
        end
        if (m_owner >= 0) begin
            m_last = m_owner;
            m_sel  = 2'(m_owner);
            m_age  = 1;
        end
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check({name, ".grant"}, bus.grant, eg);
        check({name, ".sel"}, {2'b00, bus.sel}, {2'b00, m_sel});
        check({name, ".busy"}, {3'b000, bus.busy}, {3'b000, (m_owner >= 0)});
        check({name, ".terr"}, {3'b000, bus.timeout_err}, {3'b000, m_terr});
        check({name, ".state"}, {3'b000, state_dbg}, {3'b000, (m_owner >= 0)});
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       terr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [3:0] r;
        logic       d;
        int         hold;

        n_checks = 0;
        n_errors = 0;
        model_reset();

        // Reset holds everything at zero even while all requests are asserted.
        reset_n  = 1'b0;
        bus.req  = 4'hF;
        bus.done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.grant", bus.grant, 4'b0000);
        check("rst.sel", {2'b00, bus.sel}, 4'd0);
        check("rst.busy", {3'b000, bus.busy}, 4'd0);
        check("rst.terr", {3'b000, bus.timeout_err}, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;

        vecs[0]  = '{4'hF,    1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'hF,    1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{4'hF,    1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'hF,    1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[4]  = '{4'hF,    1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[5]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[10] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[13] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].req, vecs[i].done);
            check($sformatf("vec%0d.grant", i), bus.grant, vecs[i].grant);
            check($sformatf("vec%0d.sel", i), {2'b00, bus.sel}, {2'b00, vecs[i].sel});
            check($sformatf("vec%0d.busy", i), {3'b000, bus.busy}, {3'b000, vecs[i].busy});
            check($sformatf("vec%0d.terr", i), {3'b000, bus.timeout_err}, {3'b000, vecs[i].terr});
        end

        // A grant that never sees done is held for 16 cycles, then released with a single
        // timeout_err pulse and handed straight back to the same requester.
        step(4'b0010, 1'b0);
        check("to.first", bus.grant, 4'b0010);
        for (int i = 2; i <= TIMEOUT; i++) begin
            step(4'b0010, 1'b0);
            check($sformatf("to.hold%0d", i), bus.grant, 4'b0010);
            check($sformatf("to.noerr%0d", i), {3'b000, bus.timeout_err}, 4'd0);
        end
        step(4'b0010, 1'b0);
        check("to.err", {3'b000, bus.timeout_err}, 4'd1);
        check("to.regrant", bus.grant, 4'b0010);
        step(4'b0000, 1'b0);
        check("to.errclr", {3'b000, bus.timeout_err}, 4'd0);
        check("to.abort", bus.grant, 4'b0000);
        check("to.selhold", {2'b00, bus.sel}, 4'd1);

        // A done arriving in the watchdog's last cycle takes precedence, so no timeout_err is raised.
        step(4'b0010, 1'b0);
        check("dt.first", bus.grant, 4'b0010);
        for (int i = 2; i <= TIMEOUT; i++) step(4'b0011, 1'b0);
        check("dt.held", bus.grant, 4'b0010);
        step(4'b0011, 1'b1);
        check("dt.noerr", {3'b000, bus.timeout_err}, 4'd0);
        check("dt.handoff", bus.grant, 4'b0001);

        // An asynchronous reset in the middle of a grant clears the outputs without waiting
        // for a clock edge, and arbitration then restarts at requester 0.
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst.grant", bus.grant, 4'b0000);
        check("mrst.busy", {3'b000, bus.busy}, 4'd0);
        check("mrst.terr", {3'b000, bus.timeout_err}, 4'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b1110, 1'b0);
        check_model("mrst.after");

        hold = 0;
        r    = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                r    = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 24);
            end else begin
                hold--;
            end
            d = ($urandom_range(0, 7) == 0);
            if (c == 300) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_model("rand.rst");
                @(negedge clk);
                reset_n = 1'b1;
            end
            step(r, d);
            check_model($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
